// File: rtl/imem_access_arbiter_if.sv
// Bus bundle for the IMEM access arbiter: CPU fetch port, PDU debug port and the IMEM port.
// The slave modport is the arbiter side; the master modport is the requesters-plus-IMEM side.
interface imem_access_arbiter_if #(
    parameter int DEPTH = 10
);
    logic             cpu_req;
    logic [DEPTH-1:0] cpu_addr;
    logic             cpu_gnt;
    logic             cpu_rvalid;
    logic [31:0]      cpu_rdata;

    logic             dbg_req;
    logic             dbg_we;
    logic             dbg_lock;
    logic [DEPTH-1:0] dbg_addr;
    logic [31:0]      dbg_wdata;
    logic             dbg_gnt;
    logic             dbg_rvalid;
    logic [31:0]      dbg_rdata;
    logic             dbg_locked;

    logic [DEPTH-1:0] imem_addr;
    logic             imem_we;
    logic [31:0]      imem_wdata;
    logic [31:0]      imem_rdata;

    modport slave (
        input  cpu_req, cpu_addr,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
        output imem_addr, imem_we, imem_wdata,
        input  imem_rdata
    );

    modport master (
        output cpu_req, cpu_addr,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_locked,
        input  imem_addr, imem_we, imem_wdata,
        output imem_rdata
    );
endinterface

// File: rtl/imem_access_arbiter.sv
// Shares the single-ported IMEM between CPU fetch and PDU debug/loader, with a debug lock.
// Optional IMEM_ARB_PERF_EN adds saturating conflict and debug-write counters.
module imem_access_arbiter #(
    parameter int DEPTH = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    imem_access_arbiter_if.slave  bus
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_dbg_wr_cnt
`endif
);
    typedef enum logic {ST_RR, ST_LOCKED} state_t;

    state_t state_q, state_d;
    logic   rr_last_q, rr_last_d;  // 1 = debug granted last
    logic   cpu_gnt, dbg_gnt;
    logic   lock_hold;

    // Lock release is seen combinationally, so the release cycle already arbitrates as RR.
    assign lock_hold = (state_q == ST_LOCKED) && bus.dbg_lock;

    always_comb begin
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        state_d   = state_q;
        rr_last_d = rr_last_q;
        if (lock_hold) begin
            dbg_gnt = bus.dbg_req;
        end else begin
            state_d = ST_RR;
            if (bus.cpu_req && bus.dbg_req) begin
                if (rr_last_q) cpu_gnt = 1'b1;
                else           dbg_gnt = 1'b1;
            end else begin
                cpu_gnt = bus.cpu_req;
                dbg_gnt = bus.dbg_req;
            end
            if (cpu_gnt) rr_last_d = 1'b0;
            if (dbg_gnt) rr_last_d = 1'b1;
            if (dbg_gnt && bus.dbg_lock) state_d = ST_LOCKED;
        end
        // No access may reach IMEM while reset is held
        if (!rstn) begin
            cpu_gnt = 1'b0;
            dbg_gnt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_RR;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    assign bus.cpu_gnt    = cpu_gnt;
    assign bus.dbg_gnt    = dbg_gnt;
    assign bus.dbg_locked = (state_q == ST_LOCKED);
    assign bus.imem_we    = dbg_gnt & bus.dbg_we;
    assign bus.imem_wdata = dbg_gnt ? bus.dbg_wdata : 32'h0;
    assign bus.imem_addr  = dbg_gnt ? bus.dbg_addr :
                            cpu_gnt ? bus.cpu_addr : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.cpu_rvalid <= 1'b0;
            bus.cpu_rdata  <= 32'h0;
            bus.dbg_rvalid <= 1'b0;
            bus.dbg_rdata  <= 32'h0;
        end else begin
            bus.cpu_rvalid <= cpu_gnt;
            bus.dbg_rvalid <= dbg_gnt & ~bus.dbg_we;
            if (cpu_gnt)                 bus.cpu_rdata <= bus.imem_rdata;
            if (dbg_gnt && !bus.dbg_we)  bus.dbg_rdata <= bus.imem_rdata;
        end
    end

`ifdef IMEM_ARB_PERF_EN
    logic conflict;
    assign conflict = bus.cpu_req && !cpu_gnt && (bus.dbg_req || (state_q == ST_LOCKED));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_conflict_cnt <= 32'h0;
            perf_dbg_wr_cnt   <= 32'h0;
        end else begin
            if (conflict && (perf_conflict_cnt != 32'hFFFF_FFFF))
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            if (dbg_gnt && bus.dbg_we && (perf_dbg_wr_cnt != 32'hFFFF_FFFF))
                perf_dbg_wr_cnt <= perf_dbg_wr_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_imem_access_arbiter.sv
// Self-checking bench for imem_access_arbiter: IMEM model, per-cycle grant checks and
// a read-data scoreboard. Checks perf counters when IMEM_ARB_PERF_EN is defined.
module tb_imem_access_arbiter;
    localparam int DEPTH = 10;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    imem_access_arbiter_if #(.DEPTH(DEPTH)) bus ();

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt, perf_dbg_wr_cnt;
    imem_access_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave),
        .perf_conflict_cnt(perf_conflict_cnt), .perf_dbg_wr_cnt(perf_dbg_wr_cnt));
`else
    imem_access_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
`endif

    // IMEM model and the bench's own view of what it should contain
    logic [31:0] mem     [1<<DEPTH];
    logic [31:0] ref_mem [1<<DEPTH];
    initial for (int i = 0; i < (1<<DEPTH); i++) begin
        mem[i]     = 32'hA500_0000 | i;
        ref_mem[i] = 32'hA500_0000 | i;
    end
    assign bus.imem_rdata = mem[bus.imem_addr];
    always @(posedge clk) if (bus.imem_we) mem[bus.imem_addr] <= bus.imem_wdata;

    int checks = 0;
    int fails  = 0;
    logic [31:0] cpu_q[$];
    logic [31:0] dbg_q[$];
    logic cpu_rv_exp = 1'b0;
    logic dbg_rv_exp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One cycle: responses of last cycle, grants of this one, then advance past the edge
    task automatic step(input logic ecg, input logic edg);
        @(negedge clk);
        chk("cpu_rvalid", bus.cpu_rvalid, cpu_rv_exp);
        if (cpu_rv_exp) chk("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
        chk("dbg_rvalid", bus.dbg_rvalid, dbg_rv_exp);
        if (dbg_rv_exp) chk("dbg_rdata", bus.dbg_rdata, dbg_q.pop_front());
        chk("cpu_gnt", bus.cpu_gnt, ecg);
        chk("dbg_gnt", bus.dbg_gnt, edg);
        chk("imem_we", bus.imem_we, edg & bus.dbg_we);
        cpu_rv_exp = ecg;
        if (ecg) cpu_q.push_back(ref_mem[bus.cpu_addr]);
        dbg_rv_exp = edg && !bus.dbg_we;
        if (dbg_rv_exp) dbg_q.push_back(ref_mem[bus.dbg_addr]);
        if (edg && bus.dbg_we) ref_mem[bus.dbg_addr] = bus.dbg_wdata;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_req = 0; bus.cpu_addr = '0;
        bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_lock = 0;
        bus.dbg_addr = '0; bus.dbg_wdata = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle_inputs();
        cpu_q.delete(); dbg_q.delete();
        cpu_rv_exp = 0; dbg_rv_exp = 0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    initial begin
        idle_inputs();
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_cpu_rdata",  bus.cpu_rdata, 0);
        chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
        chk("rst_dbg_rdata",  bus.dbg_rdata, 0);
        chk("rst_dbg_locked", bus.dbg_locked, 0);
        chk("rst_imem_addr",  bus.imem_addr, 0);
        do_reset();

        // Lone CPU read
        bus.cpu_req = 1; bus.cpu_addr = 10'h004;
        step(1, 0);
        bus.cpu_req = 0;
        step(0, 0);
        chk("idle_imem_addr", bus.imem_addr, 0);

        // Contention from reset: CPU, DBG, CPU, DBG
        do_reset();
        bus.cpu_req = 1; bus.cpu_addr = 10'h020;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 10'h030;
        step(1, 0); bus.cpu_addr = 10'h021;
        step(0, 1); bus.dbg_addr = 10'h031;
        step(1, 0); bus.cpu_addr = 10'h022;
        step(0, 1);
        idle_inputs();
        step(0, 0);

        // Program load under lock; CPU wins the first conflict since debug went last
        bus.cpu_req = 1; bus.cpu_addr = 10'h040;
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_lock = 1;
        bus.dbg_addr = 10'h000; bus.dbg_wdata = 32'hC0DE_0000;
        step(1, 0);
        bus.cpu_addr = 10'h003;
        for (int i = 0; i < 16; i++) begin
            bus.dbg_addr = i[DEPTH-1:0]; bus.dbg_wdata = 32'hC0DE_0000 | i;
            step(0, 1);
            chk("locked", bus.dbg_locked, 1);
        end
        bus.dbg_req = 0; bus.dbg_lock = 0; bus.dbg_we = 0;
        step(1, 0);
        chk("unlocked", bus.dbg_locked, 0);
        bus.cpu_req = 0;
        step(0, 0);
`ifdef IMEM_ARB_PERF_EN
        chk("perf_conflict", perf_conflict_cnt, 32'd18);
        chk("perf_dbg_wr", perf_dbg_wr_cnt, 32'd16);
`endif

        // Write then read-after-write on the next cycle
        bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 10'h010; bus.dbg_wdata = 32'h1234_5678;
        step(0, 1);
        idle_inputs();
        bus.cpu_req = 1; bus.cpu_addr = 10'h010;
        step(1, 0);
        bus.cpu_req = 0;
        step(0, 0);
        chk("raw_ref", ref_mem[10'h010], 32'h1234_5678);

        // dbg_lock without dbg_req must not lock
        bus.dbg_lock = 1; bus.cpu_req = 1; bus.cpu_addr = 10'h007;
        step(1, 0);
        chk("lock_noreq", bus.dbg_locked, 0);
        idle_inputs();
        step(0, 0);

        // Reset during a locked write with a read response pending
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_lock = 1; bus.dbg_addr = 10'h005;
        step(0, 1);
        chk("pend_rvalid", bus.dbg_rvalid, 1);
        chk("pend_locked", bus.dbg_locked, 1);
        bus.dbg_we = 1; bus.dbg_wdata = 32'hDEAD_BEEF; bus.cpu_req = 1; bus.cpu_addr = 10'h001;
        rstn = 1'b0;
        @(negedge clk);
        chk("r5_dbg_rvalid", bus.dbg_rvalid, 0);
        chk("r5_dbg_rdata",  bus.dbg_rdata, 0);
        chk("r5_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("r5_locked",     bus.dbg_locked, 0);
        chk("r5_imem_we",    bus.imem_we, 0);
        chk("r5_dbg_gnt",    bus.dbg_gnt, 0);
        chk("r5_cpu_gnt",    bus.cpu_gnt, 0);
        chk("r5_imem_addr",  bus.imem_addr, 0);
        @(posedge clk);
        #1;
        idle_inputs();
        cpu_q.delete(); dbg_q.delete();
        cpu_rv_exp = 0; dbg_rv_exp = 0;
        rstn = 1'b1;
        // Back in RR with rr_last reset: CPU first; addr 5 must still hold its old word
        bus.cpu_req = 1; bus.cpu_addr = 10'h005;
        bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 10'h006;
        step(1, 0);
        bus.cpu_req = 0;
        step(0, 1);
        idle_inputs();
        step(0, 0);
        chk("r5_final_locked", bus.dbg_locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
